jtroadf_objscan: RTL

Object RAM and per-line sprite scanner for the Road Fighter / Hyper Sports core. Holds both object frames written by the main CPU (CPU sees bank `obj_frame`, scanner reads the other), and on each line-start pulse walks every entry of the inactive bank. Each sprite whose vertical span covers the next rendered line is handed to the object line drawer over a valid/ready handshake. Sits between the main CPU bus (`objram_cs`, `obj_dout`, `obj_frame`) and the object drawer.

---
 rtl/jtroadf_objscan_pkg.sv | 37 +++
 rtl/jtframe_dual_ram.sv | 27 ++
 rtl/jtroadf_objscan.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/jtroadf_objscan_pkg.sv
// Shared definitions for the Road Fighter object RAM scanner.
package jtroadf_obj_pkg;

  // Scanner FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_Y,
    ST_RD_CODE,
    ST_RD_ATTR,
    ST_RD_X,
    ST_CHECK,
    ST_EMIT,
    ST_NEXT
  } objscan_state_t;

  // Byte offsets inside a 4-byte object entry
  localparam logic [1:0] OBJ_Y    = 2'd0;
  localparam logic [1:0] OBJ_CODE = 2'd1;
  localparam logic [1:0] OBJ_ATTR = 2'd2;
  localparam logic [1:0] OBJ_X    = 2'd3;

  // Attribute byte bit positions
  localparam int ATTR_VFLIP   = 7;
  localparam int ATTR_HFLIP   = 6;
  localparam int ATTR_CODE8   = 5;
  localparam int ATTR_PAL_MSB = 3;
  localparam int ATTR_PAL_LSB = 0;

  // Vertical distance from the sprite top to the line being drawn, 8-bit wrap
  function automatic logic [7:0] obj_ydiff(input logic flip, input logic [7:0] vr,
                                           input logic [7:0] y);
    logic [7:0] veff;
    veff = flip ? ~vr : vr;
    return veff - y;
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple true dual-port RAM, both ports on one clock, registered read data.
module jtframe_dual_ram #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [DW-1:0] data0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  output logic [DW-1:0] q0,
  input  logic [DW-1:0] data1,
  input  logic [AW-1:0] addr1,
  input  logic          we1,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  // Writes and registered reads for both ports
  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= data0;
    if (we1) mem[addr1] <= data1;
    q0 <= mem[addr0];
    q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtroadf_objscan.sv
// Double-buffered object RAM plus per-line sprite scanner feeding the
// object line drawer through a valid/ready handshake.
module jtroadf_objscan
  import jtroadf_obj_pkg::*;
#(
  parameter int NOBJ   = 64,
  parameter int MAXHIT = 24
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cpu_cen,
  input  logic       objram_cs,
  input  logic       cpu_rnw,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] obj_dout,
  input  logic       obj_frame,
  input  logic       flip,
  input  logic [7:0] vrender,
  input  logic       hs_start,
  output logic       dr_valid,
  input  logic       dr_ready,
  output logic [8:0] dr_code,
  output logic [7:0] dr_xpos,
  output logic [3:0] dr_row,
  output logic       dr_hflip,
  output logic [3:0] dr_pal,
  output logic       scan_done
);

  localparam int IW = $clog2(NOBJ);
  localparam int AW = IW + 3;
  localparam int HW = $clog2(MAXHIT + 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NOBJ - 1);
  localparam logic [HW-1:0] HIT_LIMIT = HW'(MAXHIT);

  objscan_state_t st;
  logic [IW-1:0]  idx, scan_idx;
  logic [HW-1:0]  hits;
  logic           bank, flip_l, dout_ok;
  logic [7:0]     vr_l, y_l, code_l, attr_l;
  logic [1:0]     byte_sel;
  logic [7:0]     ram_q0, ram_q1, ydiff;
  logic           hit;
  logic [AW-1:0]  addr0, addr1;
  logic           we0;

  assign we0   = objram_cs & ~cpu_rnw & cpu_cen;
  assign addr0 = {obj_frame, cpu_addr[IW+1:0]};
  assign addr1 = {bank, scan_idx, byte_sel};

  // RAM output has no reset; mask it until the first clock after reset
  assign obj_dout = dout_ok ? ram_q0 : '0;

  jtframe_dual_ram #(.AW(AW), .DW(8)) u_ram (
    .clk   (clk),
    .data0 (cpu_dout),
    .addr0 (addr0),
    .we0   (we0),
    .q0    (ram_q0),
    .data1 ('0),
    .addr1 (addr1),
    .we1   (1'b0),
    .q1    (ram_q1)
  );

  // Scan address: NEXT already presents the Y byte of the following entry,
  // so it doubles as that entry's first read cycle and goes straight to RD_CODE
  always_comb begin
    scan_idx = (st == ST_NEXT) ? idx - IW'(1) : idx;
    case (st)
      ST_RD_CODE: byte_sel = OBJ_CODE;
      ST_RD_ATTR: byte_sel = OBJ_ATTR;
      ST_RD_X:    byte_sel = OBJ_X;
      default:    byte_sel = OBJ_Y;
    endcase
  end

  // Vertical coverage test; Y = 0 marks an unused entry
  always_comb begin
    ydiff = obj_ydiff(flip_l, vr_l, y_l);
    hit   = (ydiff < 8'd16) && (y_l != 8'd0);
  end

  // Scanner FSM with registered descriptor outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st        <= ST_IDLE;
      idx       <= '0;
      hits      <= '0;
      bank      <= 1'b0;
      flip_l    <= 1'b0;
      vr_l      <= '0;
      y_l       <= '0;
      code_l    <= '0;
      attr_l    <= '0;
      dout_ok   <= 1'b0;
      dr_valid  <= 1'b0;
      dr_code   <= '0;
      dr_xpos   <= '0;
      dr_row    <= '0;
      dr_hflip  <= 1'b0;
      dr_pal    <= '0;
      scan_done <= 1'b1;
    end else begin
      dout_ok <= 1'b1;
      if (hs_start) begin
        bank      <= ~obj_frame;
        flip_l    <= flip;
        vr_l      <= vrender;
        idx       <= IDX_LAST;
        hits      <= '0;
        dr_valid  <= 1'b0;
        scan_done <= 1'b0;
        st        <= ST_RD_Y;
      end else begin
        case (st)
          ST_IDLE: ;
          ST_RD_Y: st <= ST_RD_CODE;
          ST_RD_CODE: begin
            y_l <= ram_q1;
            st  <= ST_RD_ATTR;
          end
          ST_RD_ATTR: begin
            code_l <= ram_q1;
            st     <= ST_RD_X;
          end
          ST_RD_X: begin
            attr_l <= ram_q1;
            st     <= ST_CHECK;
          end
          ST_CHECK: begin
            if (hit) begin
              dr_code  <= {attr_l[ATTR_CODE8], code_l};
              dr_xpos  <= ram_q1;
              dr_row   <= ydiff[3:0] ^ {4{attr_l[ATTR_VFLIP]}};
              dr_hflip <= attr_l[ATTR_HFLIP];
              dr_pal   <= attr_l[ATTR_PAL_MSB:ATTR_PAL_LSB];
              dr_valid <= 1'b1;
              st       <= ST_EMIT;
            end else begin
              st <= ST_NEXT;
            end
          end
          ST_EMIT: begin
            if (dr_ready) begin
              dr_valid <= 1'b0;
              hits     <= hits + HW'(1);
              st       <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (idx == '0 || hits == HIT_LIMIT) begin
              scan_done <= 1'b1;
              st        <= ST_IDLE;
            end else begin
              idx <= idx - IW'(1);
              st  <= ST_RD_CODE;
            end
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
